// File: rtl/scroll_sched.sv
// ============================================================================
// Module   : scroll_sched
// Purpose  : Frame-synchronised scroll scheduler. Advances the vertical line
//            offset only at blanking start. Optional macro: SCROLL_BOUNCE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module scroll_sched #(
  parameter int HEIGHT      = 240,
  parameter int VBLANK_LINE = 480,
  parameter int PERIOD_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                dir,
  input  logic [2:0]          step,
  input  logic [PERIOD_W-1:0] period,
  input  logic [9:0]          v_cnt,
  input  logic                cmd_valid,
  input  logic [7:0]          cmd_pos,
  output logic                cmd_ready,
  output logic [7:0]          pos,
  output logic                frame_tick,
  output logic                step_pulse
);

  localparam logic [8:0] C_HEIGHT = 9'(HEIGHT);
  localparam logic [7:0] C_TOP    = 8'(HEIGHT - 1);
  localparam logic [9:0] C_VBLANK = 10'(VBLANK_LINE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [9:0]            v_prev_q;
  logic [7:0]            pos_q, pos_d;
  logic [7:0]            load_q, load_d;
  logic [PERIOD_W-1:0]   fcnt_q, fcnt_d;
  logic                  frame_tick_q;
  logic                  step_pulse_q, step_pulse_d;

  logic                  w_tick;
  logic                  w_handshake;
  logic                  w_dir;
  logic [8:0]            w_fwd;
  logic [7:0]            w_next;

`ifdef SCROLL_BOUNCE_EN
  logic                  dir_q, dir_d;
  logic                  w_flip;
  assign w_dir = dir_q;
`else
  assign w_dir = dir;
`endif

  assign w_tick      = (v_cnt == C_VBLANK) && (v_prev_q != C_VBLANK);
  assign cmd_ready   = (state_q != S_PEND);
  assign w_handshake = cmd_valid && cmd_ready;

  assign pos        = pos_q;
  assign frame_tick = frame_tick_q;
  assign step_pulse = step_pulse_q;

  // Candidate position for one step; the 9-bit sum catches the overflow.
  always_comb begin
    w_fwd  = {1'b0, pos_q} + {6'd0, step};
    w_next = pos_q;
`ifdef SCROLL_BOUNCE_EN
    w_flip = 1'b0;
`endif
    if (!w_dir) begin
      if (w_fwd >= C_HEIGHT) begin
`ifdef SCROLL_BOUNCE_EN
        w_next = C_TOP;
        w_flip = 1'b1;
`else
        w_next = 8'(w_fwd - C_HEIGHT);
`endif
      end else begin
        w_next = w_fwd[7:0];
      end
    end else if (pos_q < {5'd0, step}) begin
`ifdef SCROLL_BOUNCE_EN
      w_next = 8'd0;
      w_flip = 1'b1;
`else
      w_next = 8'({1'b0, pos_q} + C_HEIGHT - {6'd0, step});
`endif
    end else begin
      w_next = pos_q - {5'd0, step};
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    fcnt_d  = fcnt_q;
    load_d  = load_q;
`ifdef SCROLL_BOUNCE_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      S_IDLE: begin
        fcnt_d = '0;
`ifdef SCROLL_BOUNCE_EN
        if (w_tick) dir_d = dir;
`endif
        if (w_handshake) begin
          state_d = S_PEND;
        end else if (en) begin
          state_d = S_RUN;
`ifdef SCROLL_BOUNCE_EN
          dir_d   = dir;
`endif
        end
      end
      S_RUN: begin
        if (!en) begin
          fcnt_d = '0;
        end else if (w_tick) begin
          if (fcnt_q == period) begin
            pos_d  = w_next;
            fcnt_d = '0;
`ifdef SCROLL_BOUNCE_EN
            if (w_flip) dir_d = ~dir_q;
`endif
          end else begin
            fcnt_d = fcnt_q + PERIOD_W'(1);
          end
        end
        // A same-cycle step still lands; the accepted load waits a frame.
        if (w_handshake)  state_d = S_PEND;
        else if (!en)     state_d = S_IDLE;
      end
      S_PEND: begin
        if (w_tick) begin
          pos_d   = load_q;
          fcnt_d  = '0;
          state_d = en ? S_RUN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_handshake) begin
      load_d = ({1'b0, cmd_pos} >= C_HEIGHT) ? C_TOP : cmd_pos;
    end
    step_pulse_d = (pos_d != pos_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      v_prev_q     <= '0;
      pos_q        <= '0;
      load_q       <= '0;
      fcnt_q       <= '0;
      frame_tick_q <= 1'b0;
      step_pulse_q <= 1'b0;
`ifdef SCROLL_BOUNCE_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      v_prev_q     <= v_cnt;
      pos_q        <= pos_d;
      load_q       <= load_d;
      fcnt_q       <= fcnt_d;
      frame_tick_q <= w_tick;
      step_pulse_q <= step_pulse_d;
`ifdef SCROLL_BOUNCE_EN
      dir_q        <= dir_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scroll_sched.sv
// ============================================================================
// Module   : tb_scroll_sched
// Purpose  : Scoreboard bench for scroll_sched with a frame-level reference.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_scroll_sched;

  localparam int H  = 240;
  localparam int VB = 480;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PEND = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic [2:0] step;
  logic [5:0] period;
  logic [9:0] v_cnt;
  logic       cmd_valid;
  logic [7:0] cmd_pos;
  logic       cmd_ready;
  logic [7:0] pos;
  logic       frame_tick;
  logic       step_pulse;

  always #5 clk = ~clk;

  scroll_sched dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dir        (dir),
    .step       (step),
    .period     (period),
    .v_cnt      (v_cnt),
    .cmd_valid  (cmd_valid),
    .cmd_pos    (cmd_pos),
    .cmd_ready  (cmd_ready),
    .pos        (pos),
    .frame_tick (frame_tick),
    .step_pulse (step_pulse)
  );

  // {frame_tick, step_pulse, cmd_ready, pos} expected in a given cycle
  typedef logic [10:0] exp_t;
  exp_t exp_q[$];

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  checking = 1'b0;
  bit  rnd_mid  = 1'b0;

  // Reference state
  int         m_pos, m_fcnt, m_load, m_mode;
  bit         m_ft, m_sp, m_dirq, m_hs;
  logic [9:0] m_vprev;

  always @(negedge clk) begin
    exp_t a, e;
    if (checking) begin
      a = {frame_tick, step_pulse, cmd_ready, pos};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL outputs t=%0t: nothing expected, actual ft/sp/rdy/pos=%b/%b/%b/%0d",
                 $time, a[10], a[9], a[8], a[7:0]);
      end else begin
        e = exp_q.pop_front();
        if (a !== e)
          $display("FAIL outputs t=%0t: actual ft/sp/rdy/pos=%b/%b/%b/%0d required %b/%b/%b/%0d",
                   $time, a[10], a[9], a[8], a[7:0], e[10], e[9], e[8], e[7:0]);
        else
          n_pass++;
      end
    end
  end

  task automatic model_reset();
    m_pos = 0; m_fcnt = 0; m_load = 0; m_mode = M_IDLE;
    m_ft = 0; m_sp = 0; m_dirq = 0; m_hs = 0; m_vprev = '0;
  endtask

  // One step of the scroll rules, returns the new position.
  function automatic int step_once(input int p);
    bit d;
    int s;
`ifdef SCROLL_BOUNCE_EN
    d = m_dirq;
`else
    d = dir;
`endif
    if (!d) begin
      s = p + int'(step);
      if (s >= H) begin
`ifdef SCROLL_BOUNCE_EN
        s = H - 1; m_dirq = ~m_dirq;
`else
        s = s - H;
`endif
      end
    end else if (p < int'(step)) begin
`ifdef SCROLL_BOUNCE_EN
      s = 0; m_dirq = ~m_dirq;
`else
      s = p + H - int'(step);
`endif
    end else begin
      s = p - int'(step);
    end
    return s;
  endfunction

  task automatic model_cycle();
    bit tick, hs;
    int np;
    exp_q.push_back({m_ft, m_sp, (m_mode != M_PEND), 8'(m_pos)});
    tick = (v_cnt == 10'(VB)) && (m_vprev != 10'(VB));
    hs   = cmd_valid && (m_mode != M_PEND);
    m_vprev = v_cnt;
    np = m_pos;
    case (m_mode)
      M_IDLE: begin
        m_fcnt = 0;
`ifdef SCROLL_BOUNCE_EN
        if (tick || (en && !hs)) m_dirq = dir;
`endif
        if (!hs && en) m_mode = M_RUN;
      end
      M_RUN: begin
        if (!en) m_fcnt = 0;
        else if (tick) begin
          if (m_fcnt == int'(period)) begin
            np = step_once(m_pos);
            m_fcnt = 0;
          end else begin
            m_fcnt = (m_fcnt + 1) % 64;
          end
        end
        if (!hs && !en) m_mode = M_IDLE;
      end
      default: begin
        if (tick) begin
          np = m_load;
          m_fcnt = 0;
          m_mode = en ? M_RUN : M_IDLE;
        end
      end
    endcase
    if (hs) begin
      m_load = (int'(cmd_pos) >= H) ? H - 1 : int'(cmd_pos);
      m_mode = M_PEND;
    end
    m_ft  = tick;
    m_sp  = (np != m_pos);
    m_pos = np;
    m_hs  = hs;
  endtask

  // Commit the current inputs for one clock; requester drops valid after handshake.
  task automatic cyc(input logic [9:0] v);
    v_cnt = v;
    model_cycle();
    @(posedge clk);
    #1;
    if (m_hs) cmd_valid = 1'b0;
    if (rnd_mid && $urandom_range(7) == 0) begin
      dir  = 1'($urandom);
      step = 3'($urandom);
    end
  endtask

  task automatic frame(input int na, input int nb, input bit cmd_tick, input logic [7:0] cp);
    for (int i = 0; i < na; i++) cyc(10'($urandom_range(479)));
    if (cmd_tick && !cmd_valid) begin
      cmd_valid = 1'b1;
      cmd_pos   = cp;
    end
    cyc(10'(VB));
    cyc(10'(VB));
    for (int i = 2; i < nb; i++) cyc(10'($urandom_range(524, 481)));
  endtask

  task automatic rst_pulse(input int n);
    rst = 1'b0;
    cmd_valid = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, 1'b0, 1'b1, 8'd0});
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; dir = 1'b0; step = '0; period = '0;
    v_cnt = '0; cmd_valid = 1'b0; cmd_pos = '0;
    model_reset();
    @(posedge clk);
    #1;
    checking = 1'b1;
    rst_pulse(2);

    // idle frames, then a reset in the middle of a scrolling frame
    repeat (3) frame(4, 3, 1'b0, 8'd0);
    en = 1'b1; step = 3'd3; period = '0;
    frame(4, 3, 1'b0, 8'd0);
    cyc(10'd100); cyc(10'd101);
    en = 1'b0;
    rst_pulse(3);
    repeat (2) frame(4, 3, 1'b0, 8'd0);

    // forward wrap from 236 with step 7
    cmd_valid = 1'b1; cmd_pos = 8'd236;
    frame(3, 3, 1'b0, 8'd0);
    en = 1'b1; dir = 1'b0; step = 3'd7; period = '0;
    frame(3, 3, 1'b0, 8'd0);

    // backward from 1, step 2, every third frame
    en = 1'b0;
    cmd_valid = 1'b1; cmd_pos = 8'd1;
    frame(3, 3, 1'b0, 8'd0);
    en = 1'b1; dir = 1'b1; step = 3'd2; period = 6'd2;
    repeat (6) frame(3, 3, 1'b0, 8'd0);

    // clamp of an out-of-range load, second request held through PEND
    cmd_valid = 1'b1; cmd_pos = 8'd250;
    cyc(10'd50);
    cmd_valid = 1'b1; cmd_pos = 8'd100;
    repeat (3) frame(3, 3, 1'b0, 8'd0);

    // handshake on the tick cycle, then en falling on a tick cycle
    period = '0; step = 3'd5; dir = 1'b0;
    frame(3, 3, 1'b1, 8'd20);
    frame(3, 3, 1'b0, 8'd0);
    cyc(10'd100); cyc(10'd200);
    en = 1'b0;
    cyc(10'(VB)); cyc(10'(VB)); cyc(10'd490);
    frame(3, 3, 1'b0, 8'd0);

    // randomized traffic
    rnd_mid = 1'b1;
    for (int f = 0; f < 200; f++) begin
      en     = ($urandom_range(9) != 0);
      dir    = 1'($urandom);
      step   = 3'($urandom);
      period = 6'($urandom_range(3));
      if (!cmd_valid && $urandom_range(4) == 0) begin
        cmd_valid = 1'b1;
        cmd_pos   = 8'($urandom);
      end
      if (f == 100) begin
        cyc(10'd33);
        rst_pulse(2);
      end
      frame($urandom_range(6, 1), $urandom_range(4, 2),
            ($urandom_range(5) == 0), 8'($urandom));
    end
    rnd_mid = 1'b0;

    checking = 1'b0;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scroll_sched.md
# scroll_sched

Frame-synchronised scroll scheduler for the VGA image-scroll datapath. Produces the vertical line offset `pos` consumed by the memory address generator, advancing it only at the start of vertical blanking so no frame ever shows a tear. Supports programmable step size and frame period, and an absolute-position load via a valid/ready handshake. Runs in the pixel-clock domain alongside the VGA controller.

## Interface
- `HEIGHT`, 240: image height in lines; `pos` range is 0..HEIGHT-1.
- `VBLANK_LINE`, 480: `v_cnt` value marking the first blanking line.
- `PERIOD_W`, 6: width of the frame-period field.
- `clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  scroll enable (level).
- `dir`  in  1  0 = increasing `pos`, 1 = decreasing `pos`.
- `step`  in  3  lines moved per update, 0..7. 0 means hold.
- `period`  in  PERIOD_W  frames between updates minus one. 0 means every frame.
- `v_cnt`  in  10  vertical counter from the VGA controller.
- `cmd_valid`  in  1  absolute-load request.
- `cmd_pos`  in  8  requested position.
- `cmd_ready`  out  1  load command can be accepted.
- `pos`  out  8  current line offset.
- `frame_tick`  out  1  one-cycle pulse at blanking start.
- `step_pulse`  out  1  one-cycle pulse when `pos` changes.

## Operation
- **Blanking detect.**
  - `v_cnt` is registered into `v_prev`.
  - `tick` = (`v_cnt`==VBLANK_LINE) && (`v_prev`!=VBLANK_LINE).
  - `frame_tick` is `tick`, registered.
- **States:** IDLE, RUN, PEND.
  - IDLE: `pos` holds and the frame counter `fcnt` is held at 0. `en`=1 → RUN.
  - RUN: on `tick`, if `fcnt`==`period`, apply a step and clear `fcnt`; otherwise increment `fcnt`. `en`=0 → IDLE, with `fcnt` cleared.
  - PEND: entered from IDLE or RUN on a handshake (`cmd_valid` && `cmd_ready`). The accepted value is latched into `load_q`.
  - PEND on `tick`: `pos`←`load_q`, `fcnt`←0, then go to RUN if `en`=1, else IDLE. No step is applied on that tick, so load takes priority over step.
- **Handshake.**
  - `cmd_ready` = (state != PEND).
  - A `cmd_valid` arriving while in PEND stalls until PEND exits.
  - The requester holds `cmd_valid` and `cmd_pos` stable until the handshake.
- **Load clamp.** A `cmd_pos` ≥ HEIGHT is clamped to HEIGHT-1 at acceptance.
- **Step arithmetic.** Uses a 9-bit intermediate.
  - Forward: s = `pos`+`step`; if s ≥ HEIGHT, s −= HEIGHT.
  - Backward: if `pos` < `step`, s = `pos`+HEIGHT−`step`; else s = `pos`−`step`.
  - `step`=0 leaves `pos` unchanged and produces no `step_pulse`.
- **Sampling.** `dir`, `step` and `period` are sampled only on `tick`. Mid-frame changes take effect at the next blanking.
- **`step_pulse`** asserts when an applied step or load changes `pos`.

## Timing
- **Reset values:**
  - `pos`=0, `fcnt`=0, state=IDLE.
  - `frame_tick`=0, `step_pulse`=0, `cmd_ready`=1.
- **Tick timing.** `v_cnt` reaches VBLANK_LINE in cycle N. `tick` is combinational in N. `frame_tick` is high in N+1.
- **Update latency.** `pos` and `step_pulse` take their new values in N+1, concurrent with `frame_tick`. This is one cycle after `tick`, far inside blanking.
- **Handshake latency.**
  - The handshake completes on the edge where `cmd_valid` && `cmd_ready`.
  - `cmd_ready` falls in the next cycle.
  - `cmd_ready` rises in the cycle after the applying `tick`.
- **Same-cycle handshake and `tick` (from RUN).** The pending step is applied, or `fcnt` increments, as normal. The load applies at the following frame.
- **`en` falls on a `tick` cycle (RUN).** No step; go to IDLE.
- **Mid-operation reset.** `rst` low forces all reset values immediately and drops a pending load.

## Configuration
- **Macro:** `SCROLL_BOUNCE_EN`.
- **Defined:**
  - An internal `dir_q` is loaded from `dir` on the IDLE→RUN transition and on every `tick` in IDLE. `dir_q` replaces `dir` in the step arithmetic.
  - Forward overflow (s ≥ HEIGHT) sets `pos`=HEIGHT-1 and inverts `dir_q`.
  - Backward underflow (`pos` < `step`) sets `pos`=0 and inverts `dir_q`.
  - No wrap ever occurs.
- **Undefined:** modulo wrap as specified in Operation. `dir` is used directly and there is no `dir_q`.

## Test plan
- **Reset and idle.** Drive `rst` low mid-frame, then high. `pos`=0, `cmd_ready`=1, `frame_tick` pulses once per frame, and `pos` stays 0 while `en`=0.
- **Forward wrap.** `en`=1, `dir`=0, `step`=7, `period`=0, `pos`=236. After one frame, `pos`=3 with `step_pulse`=1 in the `frame_tick` cycle.
- **Backward and period.** `dir`=1, `step`=2, `period`=2, start at `pos`=1.
  - `pos`=239 after the 3rd `tick` and 237 after the 6th.
  - No change on the other ticks.
- **Load and clamp.** In RUN, send `cmd_pos`=250.
  - `cmd_ready` drops one cycle after the handshake.
  - At the next `tick`, `pos`=239 and no step is applied.
  - `cmd_ready` returns high one cycle later.
  - A second `cmd_valid` held during PEND is accepted only after that.
- **Collision.** Handshake in the same cycle as `tick`. The step applies this frame and the load applies the next frame. Drop `en` on a `tick` cycle: no step, state goes to IDLE.
- **`SCROLL_BOUNCE_EN` build.** `pos`=236, `step`=7, `dir`=0. Next `pos`=239, and `pos`=232 on the following update.
